// File: rtl/clock_ctrl_pkg.sv
// Shared types and default widths for the toggle-clock sequencer.
// The burst feature is enabled by defining CLOCK_CTRL_BURST_EN.
package clock_ctrl_pkg;

    localparam int W_DIV_DEFAULT = 16;
    localparam int W_CNT_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STOPPING
    } state_t;

endpackage

// File: rtl/clock_ctrl_rollover_gen.sv
// Period counter for the toggle-clock generator: counts 0..div while enabled
// and emits a registered one-cycle tick on each wrap.
module rollover_gen
    import clock_ctrl_pkg::*;
#(
    parameter int W_DIV = W_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [W_DIV-1:0] div,
    output logic             wrap,
    output logic             tick
);

    logic [W_DIV-1:0] cnt;

    // wrap is combinational so the sequencer can count the edge in the same cycle the tick is registered.
    assign wrap = enable && (cnt == div);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (clear || wrap) begin
                cnt <= '0;
            end else if (enable) begin
                cnt <= cnt + W_DIV'(1);
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Sequencer for the toggle-clock generator: arms, runs and parks the generated clock high.
// Define CLOCK_CTRL_BURST_EN to enable fixed-length burst runs.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int W_DIV = W_DIV_DEFAULT,
    parameter int W_CNT = W_CNT_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [W_DIV-1:0] i_cfg_div,
    input  logic [W_CNT-1:0] i_cfg_burst,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_clk_reset,
    output logic             o_roll_over,
    output logic             o_running,
    output logic [W_CNT-1:0] o_edges,
    output logic             o_done
);

    state_t           state;
    logic [W_DIV-1:0] div_q;
    logic [W_CNT-1:0] edges_inc;
    logic             wrap;
    logic             enable;
    logic             burst_end;

`ifdef CLOCK_CTRL_BURST_EN
    logic [W_CNT-1:0] burst_q;
    assign burst_end = (burst_q != '0) && wrap && (edges_inc == burst_q);
`else
    wire unused_cfg_burst = ^i_cfg_burst;
    assign burst_end = 1'b0;
`endif

    assign o_cfg_ready = (state == IDLE);
    assign edges_inc   = o_edges + W_CNT'(1);
    // An odd edge count in STOPPING means the generator sits low, so keep ticking once more.
    assign enable      = (state == RUN) || ((state == STOPPING) && o_edges[0]);

    rollover_gen #(.W_DIV(W_DIV)) u_rollover_gen (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (state == ARM),
        .enable (enable),
        .div    (div_q),
        .wrap   (wrap),
        .tick   (o_roll_over)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            div_q       <= '0;
`ifdef CLOCK_CTRL_BURST_EN
            burst_q     <= '0;
`endif
            o_clk_reset <= 1'b1;
            o_running   <= 1'b0;
            o_edges     <= '0;
            o_done      <= 1'b0;
        end else begin
            o_clk_reset <= 1'b0;
            o_done      <= 1'b0;
            if (wrap) begin
                o_edges <= edges_inc;
            end
            case (state)
                IDLE: begin
                    if (i_cfg_valid) begin
                        div_q   <= i_cfg_div;
`ifdef CLOCK_CTRL_BURST_EN
                        burst_q <= i_cfg_burst;
`endif
                    end
                    if (i_start) begin
                        state       <= ARM;
                        o_clk_reset <= 1'b1;
                        o_edges     <= '0;
                    end
                end
                ARM: begin
                    if (i_stop) begin
                        state <= IDLE;
                    end else begin
                        state     <= RUN;
                        o_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_stop || burst_end) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (!o_edges[0]) begin
                        state     <= IDLE;
                        o_running <= 1'b0;
                        o_done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
